// File: rtl/iot_event_serializer.sv
// iot_event_serializer: turns net per-device status transitions into one registered
// change/on_off/dev_id event per clock, arbitrated round-robin across devices.
module iot_event_serializer #(
   parameter int N_DEV = 8,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_DEV-1:0] dev_active,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic             busy
);
   localparam int IW = ID_W + 1;

   logic [N_DEV-1:0] reported_q, reported_d, pending, sel_mask;
   logic [ID_W-1:0]  rr_q, rr_d, dev_id_q, dev_id_d, sel;
   logic [IW-1:0]    idx;
   logic             found, change_q, change_d, on_off_q, on_off_d, busy_q, busy_d;

   assign pending  = dev_active ^ reported_q;
   assign sel_mask = N_DEV'(1) << sel;

   // Scan starts at rr_q and wraps at N_DEV, so ids beyond N_DEV-1 are never visited
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_DEV; i++) begin
         idx = {1'b0, rr_q} + IW'(i);
         idx = (idx >= IW'(N_DEV)) ? idx - IW'(N_DEV) : idx;
         if (!found && pending[idx[ID_W-1:0]]) begin
            sel   = idx[ID_W-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      reported_d = reported_q;
      rr_d       = rr_q;
      change_d   = 1'b0;
      on_off_d   = on_off_q;
      dev_id_d   = dev_id_q;
      busy_d     = |pending;
      if (en) begin
         busy_d = |(pending & ~sel_mask);
         if (found) begin
            change_d   = 1'b1;
            on_off_d   = dev_active[sel];
            dev_id_d   = sel;
            reported_d = (reported_q & ~sel_mask) | (dev_active & sel_mask);
            rr_d       = (sel == ID_W'(N_DEV - 1)) ? '0 : sel + ID_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reported_q <= '0;
         rr_q       <= '0;
         change_q   <= 1'b0;
         on_off_q   <= 1'b0;
         dev_id_q   <= '0;
         busy_q     <= 1'b0;
      end else begin
         reported_q <= reported_d;
         rr_q       <= rr_d;
         change_q   <= change_d;
         on_off_q   <= on_off_d;
         dev_id_q   <= dev_id_d;
         busy_q     <= busy_d;
      end
   end

   assign change = change_q;
   assign on_off = on_off_q;
   assign dev_id = dev_id_q;
   assign busy   = busy_q;
endmodule

// File: doc/iot_event_serializer.md
Name: iot_event_serializer

Overview:
Upstream feeder for the active IoT devices monitor. Watches N_DEV per-device activity lines and converts every net status transition into a single-cycle change/on_off event, at most one event per clock. Arbitration is round-robin. Drives the monitor's change and on_off inputs directly. The monitor count therefore always converges to the number of devices reported active.

Parameters:
N_DEV, 8, number of monitored devices (2..32)
ID_W, 3, width of dev_id; must satisfy 2^ID_W >= N_DEV

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
en  input  1  1 = events may be issued; 0 = freeze (no events, reported state held)
dev_active  input  N_DEV  synchronous level per device, 1 = device on
change  output  1  registered; 1 for one cycle per issued event
on_off  output  1  registered; direction of the event, 1 = device turned on (count up), 0 = turned off (count down)
dev_id  output  ID_W  registered; index of the device the current event refers to
busy  output  1  registered; 1 if any mismatch remains pending after this cycle's event

Behaviour:
- Internal state: reported[N_DEV] holds the last status issued per device. rr_ptr[ID_W] is the round-robin start index.
- Reset (async, any time): reported=0, rr_ptr=0, change=0, on_off=0, dev_id=0, busy=0. Any pending events are discarded.
- pending = dev_active XOR reported. This is combinational from current inputs.
- At each rising edge with rst=0:
  - en=0: change<=0; reported, rr_ptr, on_off and dev_id hold; busy<=|pending.
  - en=1 and pending==0: change<=0; on_off and dev_id hold; busy<=0.
  - en=1 and pending!=0:
    - sel = first set bit of pending, scanning rr_ptr, rr_ptr+1, ... N_DEV-1, 0, ... with wrap.
    - change<=1, on_off<=dev_active[sel], dev_id<=sel.
    - reported[sel]<=dev_active[sel].
    - rr_ptr<=(sel==N_DEV-1) ? 0 : sel+1.
    - busy<=1 if pending has any bit other than sel set, else 0.
- Latency: dev_active changing before edge k produces change=1 after edge k, provided the device wins arbitration. The monitor consumes the event at edge k+1.
- Throughput: one event per cycle. M simultaneous transitions drain in exactly M consecutive cycles, provided en=1 and no further input changes.
- Net-change semantics: a device that toggles and returns before it is served generates no event (pending bit clears). A device is never reported twice in the same direction consecutively.
- Invariant: popcount(reported) equals the monitor count, given the monitor starts at 0 and consumes every change pulse. on_off is never 0 on an event while reported[sel]==0.
- rr_ptr values >= N_DEV cannot occur; the implementation must wrap at N_DEV, not at 2^ID_W.
- dev_active is assumed already synchronous to clk; no synchroniser inside.

Test Plan:
- Reset: hold rst=1 with dev_active=8'hFF for 5 cycles -> change=0, busy=0, dev_id=0. Release rst, en=1 -> 8 events on dev_id 0,1,...,7, all on_off=1, change high for 8 consecutive cycles. busy drops with the 8th event.
- Single device: from idle all-zero, set dev_active[3]=1 -> one cycle later change=1, on_off=1, dev_id=3; then change=0. Clear bit 3 -> one event, on_off=0, dev_id=3.
- Round-robin fairness: rr_ptr=4 after serving device 3. Raise bits 1, 5 and 6 together -> events in order dev_id 5, 6, 1.
- Glitch cancel: set dev_active=8'h0F (4 events pending). Pulse bit 7 high for one cycle while events drain -> no event ever issued for device 7, unless it was selected in that cycle. Direct the case where it is not selected: exactly 4 events.
- Freeze: en=0, toggle bits 0 and 2 on -> change stays 0, busy=1. Set en=1 -> two events, dev_id 0 then 2, on_off=1.
- Reset mid-drain: after 2 of 4 pending events, assert rst for one cycle while holding inputs -> outputs 0 immediately (async). After release, all 4 currently-active devices are reported again from reported=0.
